// File: rtl/sa_pkg.sv
// Shared types and width defaults for the input-stationary systolic array controller.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PROC  = 2'd2,
    DRAIN = 2'd3
  } sa_state_t;

  localparam int SA_INPUT_WIDTH  = 16;
  localparam int SA_WEIGHT_WIDTH = 16;
  localparam int SA_ARRAY_HEIGHT = 4;
  localparam int SA_ARRAY_WIDTH  = 4;
  localparam int SA_CNT_WIDTH    = 16;

  // A weight row needs HEIGHT+WIDTH cycles to cross the array and emerge as a psum row.
  function automatic int sa_drain_lat(input int height, input int width);
    return height + width;
  endfunction

  localparam int SA_DRAIN_LAT = sa_drain_lat(SA_ARRAY_HEIGHT, SA_ARRAY_WIDTH);

endpackage

// File: rtl/sa_valid_delay.sv
// Fixed-depth 1-bit delay line with async clear; carries the result-row tag through the array.
module sa_valid_delay #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] pipe;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pipe <= '0;
        else        pipe <= d;
    end else begin : g_many
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pipe <= '0;
        else        pipe <= {pipe[DEPTH-2:0], d};
    end
  endgenerate

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/systolic_array_is_ctrl.sv
// Job sequencer for the input-stationary systolic array: load activations, stream weights, drain.
// Optional SA_CTRL_PERF_EN adds busy-cycle and weight-bubble counters for the last job.
module systolic_array_is_ctrl
  import sa_pkg::*;
#(
  parameter int INPUT_WIDTH  = SA_INPUT_WIDTH,
  parameter int WEIGHT_WIDTH = SA_WEIGHT_WIDTH,
  parameter int ARRAY_HEIGHT = SA_ARRAY_HEIGHT,
  parameter int ARRAY_WIDTH  = SA_ARRAY_WIDTH,
  parameter int DRAIN_LAT    = sa_drain_lat(ARRAY_HEIGHT, ARRAY_WIDTH),
  parameter int CNT_WIDTH    = SA_CNT_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [CNT_WIDTH-1:0]                num_wrows,
  output logic                                busy,
  output logic                                done,
  input  logic                                act_valid,
  output logic                                act_ready,
  input  logic [ARRAY_HEIGHT*INPUT_WIDTH-1:0] act_data,
  input  logic                                wgt_valid,
  output logic                                wgt_ready,
  input  logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0] wgt_data,
  output logic                                input_en,
  output logic [ARRAY_HEIGHT*INPUT_WIDTH-1:0] input_out,
  output logic                                process_en,
  output logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0] weight_out,
  output logic                                psum_valid
`ifdef SA_CTRL_PERF_EN
  ,
  output logic [31:0]                         perf_cycles,
  output logic [31:0]                         perf_bubbles
`endif
);

  localparam int LW = $clog2(ARRAY_HEIGHT + 1);
  localparam int DW = $clog2(DRAIN_LAT + 1);

  sa_state_t            state;
  logic [CNT_WIDTH-1:0] nw_q;
  logic [CNT_WIDTH-1:0] wcnt;
  logic [LW-1:0]        lcnt;
  logic [DW-1:0]        dcnt;
  logic                 beat;
  logic                 go;

  assign busy       = (state != IDLE);
  assign act_ready  = (state == LOAD);
  assign wgt_ready  = (state == PROC);
  assign process_en = (state == PROC) || (state == DRAIN);
  assign input_en   = act_valid & act_ready;
  assign beat       = wgt_valid & wgt_ready;
  assign input_out  = input_en ? act_data : '0;
  assign weight_out = beat ? wgt_data : '0;
  // The done cycle is already IDLE, but a start there still belongs to the finishing job.
  assign go         = (state == IDLE) && start && !done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      nw_q  <= '0;
      wcnt  <= '0;
      lcnt  <= '0;
      dcnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (go) begin
          state <= LOAD;
          nw_q  <= num_wrows;
          lcnt  <= '0;
        end
        LOAD: if (act_valid) begin
          if (lcnt == LW'(ARRAY_HEIGHT - 1)) begin
            lcnt <= '0;
            if (nw_q == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= PROC;
              wcnt  <= '0;
            end
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        PROC: if (wgt_valid) begin
          if (wcnt == nw_q - 1'b1) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        DRAIN: begin
          if (dcnt == DW'(DRAIN_LAT - 1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sa_valid_delay #(.DEPTH(DRAIN_LAT)) u_vld (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (beat),
    .q     (psum_valid)
  );

`ifdef SA_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles  <= '0;
      perf_bubbles <= '0;
    end else if (go) begin
      perf_cycles  <= '0;
      perf_bubbles <= '0;
    end else begin
      if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
      if (state == PROC && !wgt_valid && perf_bubbles != '1) perf_bubbles <= perf_bubbles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_array_is_ctrl.sv
// Self-checking bench: event-level reference model plus a behavioural array for result rows.
module tb_systolic_array_is_ctrl;

  localparam int IW = 16, WW = 16, H = 4, W = 4, DL = 8, CW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [CW-1:0]   num_wrows = '0;
  logic            busy, done;
  logic            act_valid = 1'b0;
  logic            act_ready;
  logic [H*IW-1:0] act_data = '0;
  logic            wgt_valid = 1'b0;
  logic            wgt_ready;
  logic [W*WW-1:0] wgt_data = '0;
  logic            input_en;
  logic [H*IW-1:0] input_out;
  logic            process_en;
  logic [W*WW-1:0] weight_out;
  logic            psum_valid;
`ifdef SA_CTRL_PERF_EN
  logic [31:0]     perf_cycles, perf_bubbles;
`endif

  always #5 clk = ~clk;

  systolic_array_is_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_wrows(num_wrows), .busy(busy), .done(done),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_data(wgt_data),
    .input_en(input_en), .input_out(input_out), .process_en(process_en),
    .weight_out(weight_out), .psum_valid(psum_valid)
`ifdef SA_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_bubbles(perf_bubbles)
`endif
  );

  int n_chk, n_fail;

  // Model: phase 0 idle, 1 load, 2 proc, 3 drain; psum times kept as an ordered schedule.
  int  m_phase, m_lcnt, m_wcnt, m_dcnt, m_nw, cyc;
  bit  m_done, last_done;
  int  sched[$];
  longint m_pc, m_pb;

  logic [W*WW-1:0]  hist [64];
  logic [H*IW-1:0]  acap_rows [H];
  int               acap, n_pv;
  logic [W*32-1:0]  res_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_lcnt = 0; m_wcnt = 0; m_dcnt = 0; m_nw = 0;
    m_done = 0; m_pc = 0; m_pb = 0;
    sched.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_act_ready"}, act_ready, 0);
    chk({tag, "_wgt_ready"}, wgt_ready, 0);
    chk({tag, "_input_en"}, input_en, 0);
    chk({tag, "_process_en"}, process_en, 0);
    chk({tag, "_psum_valid"}, psum_valid, 0);
    chk({tag, "_input_out"}, input_out, 0);
    chk({tag, "_weight_out"}, weight_out, 0);
  endtask

  function automatic logic [W*32-1:0] row_result(input logic [W*WW-1:0] w);
    logic [W*32-1:0] r;
    r = '0;
    for (int j = 0; j < W; j++)
      for (int k = 0; k < H; k++)
        r[j*32 +: 32] += 32'(w[k*WW +: WW]) * 32'(acap_rows[k][j*IW +: IW]);
    return r;
  endfunction

  // Directed matrices: activation row k element j = 4k+j+1, weight row r element k = 4r+k+1.
  function automatic logic [H*IW-1:0] act_row(input int k);
    logic [H*IW-1:0] r;
    for (int j = 0; j < H; j++) r[j*IW +: IW] = IW'(4*k + j + 1);
    return r;
  endfunction

  function automatic logic [W*WW-1:0] wgt_row(input int r);
    logic [W*WW-1:0] v;
    for (int k = 0; k < W; k++) v[k*WW +: WW] = WW'(4*r + k + 1);
    return v;
  endfunction

  function automatic logic [W*32-1:0] exp_row(input int r);
    logic [W*32-1:0] v;
    v = '0;
    for (int j = 0; j < W; j++)
      for (int k = 0; k < H; k++) v[j*32 +: 32] += 32'((4*r + k + 1) * (4*k + j + 1));
    return v;
  endfunction

  task automatic tick(input bit av, input logic [H*IW-1:0] ad, input bit wv,
                      input logic [W*WW-1:0] wd, input bit st, input logic [CW-1:0] nw);
    bit ie, bt, pv, dn;
    @(negedge clk);
    act_valid = av; act_data = ad; wgt_valid = wv; wgt_data = wd; start = st; num_wrows = nw;
    #1;
    ie = av && m_phase == 1;
    bt = wv && m_phase == 2;
    pv = sched.size() > 0 && sched[0] == cyc;
    if (pv) void'(sched.pop_front());
    chk("busy", busy, m_phase != 0);
    chk("act_ready", act_ready, m_phase == 1);
    chk("wgt_ready", wgt_ready, m_phase == 2);
    chk("process_en", process_en, m_phase >= 2);
    chk("input_en", input_en, ie);
    chk("input_out", input_out, ie ? ad : '0);
    chk("weight_out", weight_out, bt ? wd : '0);
    chk("psum_valid", psum_valid, pv);
    chk("done", done, m_done);
`ifdef SA_CTRL_PERF_EN
    chk("perf_cycles", perf_cycles, m_pc[31:0]);
    chk("perf_bubbles", perf_bubbles, m_pb[31:0]);
`endif
    last_done = m_done;
    hist[cyc % 64] = weight_out;
    if (input_en && acap < H) begin acap_rows[acap] = input_out; acap++; end
    if (psum_valid) begin res_q.push_back(row_result(hist[(cyc - DL) % 64])); n_pv++; end
    dn = 0;
    if (m_phase != 0) m_pc++;
    case (m_phase)
      0: if (st && !m_done) begin m_phase = 1; m_nw = int'(nw); m_lcnt = 0; m_pc = 0; m_pb = 0; end
      1: if (av) begin
        m_lcnt++;
        if (m_lcnt == H) begin
          if (m_nw == 0) begin m_phase = 0; dn = 1; end
          else begin m_phase = 2; m_wcnt = 0; end
        end
      end
      2: begin
        if (!wv) m_pb++;
        else begin
          sched.push_back(cyc + DL);
          m_wcnt++;
          if (m_wcnt == m_nw) begin m_phase = 3; m_dcnt = 0; end
        end
      end
      default: begin
        m_dcnt++;
        if (m_dcnt == DL) begin m_phase = 0; dn = 1; end
      end
    endcase
    m_done = dn;
    cyc++;
  endtask

  function automatic bit pick(input int mode, input int i);
    case (mode)
      0: return 1'b1;
      1: return (i % 2) == 0;
      2: return 1'($urandom % 2);
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic run_job(input int nw, input int amode, input int wmode, input bit spam, input bit dir);
    bit av, wv, ended;
    logic [H*IW-1:0] ad;
    logic [W*WW-1:0] wd;
    acap = 0; n_pv = 0; res_q.delete(); ended = 0;
    tick(0, '0, 0, '0, 1, CW'(nw));
    for (int g = 0; g < 3000; g++) begin
      av = pick(amode, g);
      wv = pick(wmode, g);
      ad = dir ? act_row(m_lcnt) : {$urandom, $urandom};
      wd = dir ? wgt_row(m_wcnt) : {$urandom, $urandom};
      tick(av, ad, wv, wd, spam, spam ? CW'($urandom) : CW'(nw));
      if (last_done) begin ended = 1; break; end
    end
    chk("job_done_seen", ended, 1);
    chk("act_rows_loaded", acap, H);
    chk("psum_count", n_pv, nw);
    if (dir) begin
      chk("res_rows", res_q.size(), nw);
      for (int r = 0; r < nw && r < res_q.size(); r++)
        chk($sformatf("result_row%0d", r), res_q[r], exp_row(r));
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    model_reset();
    #3;
    chk_all_zero("reset");
    #9 rst_n = 1'b1;

    // 1: directed 4x4 job, all valids high
    run_job(4, 0, 0, 0, 1);
    // 2: alternating weight bubbles, same results
    run_job(4, 0, 1, 0, 1);
`ifdef SA_CTRL_PERF_EN
    chk("perf_bubbles_alt", perf_bubbles, 3);
`endif
    // 3: zero weight rows
    run_job(0, 0, 0, 0, 0);
    // 4: start held through the job and the done cycle, then immediate restart
    run_job(5, 3, 3, 1, 0);
    run_job(3, 0, 0, 0, 0);

    // 5: reset in the middle of PROC
    tick(0, '0, 0, '0, 1, CW'(6));
    for (int i = 0; i < 4; i++) tick(1, {$urandom, $urandom}, 0, '0, 0, '0);
    for (int i = 0; i < 2; i++) tick(0, '0, 1, {$urandom, $urandom}, 0, '0);
    @(negedge clk);
    act_valid = 1'b1; wgt_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
`ifdef SA_CTRL_PERF_EN
    chk("midreset_perf_cycles", perf_cycles, 0);
`endif
    model_reset();
    for (int i = 0; i < 2; i++) tick(1, '0, 1, '0, 0, '0);
    rst_n = 1'b1;
    for (int i = 0; i < DL + 2; i++) tick(0, '0, 0, '0, 0, '0);
    run_job(4, 0, 0, 0, 1);

    // 6: toggling activation valid
    run_job(2, 1, 0, 0, 0);
    run_job(3, 2, 2, 0, 1);

    // random jobs
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom % 2), 0);
    run_job(40, 3, 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
